if_fetch: RTL and testbench

Instruction-fetch stage of the five-stage pipeline: owns the program counter, issues word reads to instruction memory over a req/ready handshake, and drives the pc/instruction pair into the IF/ID pipeline register. It handles taken-branch/jump redirects from EX and the load-use stall from the hazard unit. When no instruction can be delivered it inserts a NOP bubble.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/if_fetch_if.sv | 31 +++
 rtl/pc_gen.sv | 35 +++
 rtl/if_fetch.sv | 106 ++++++++++
 tb/tb_if_fetch.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: constants and types shared by the pipeline stages.
//   XLEN          : datapath width
//   NOP_INST      : addi x0,x0,0. IF/ID and ID/EX use the same word for bubbles.
//   PC_STEP       : byte distance between two consecutive instruction words
//   fetch_state_e : fetch FSM states
//                   FETCH : a request is on the bus
//                   HOLD  : a response was taken during a stall and sits in the buffer
package pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction-memory read bus between the fetch stage and imem.
//   imem_req   : read request valid (fetch -> mem)
//   imem_addr  : word-aligned read address (fetch -> mem)
//   imem_ready : imem_rdata is valid. A transfer completes when req && ready (mem -> fetch)
//   imem_rdata : instruction word (mem -> fetch)
// Modports:
//   master : the fetch side
//   slave  : the memory side
interface if_fetch_if;
  import pipe_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/pc_gen.sv
// pc_gen: program counter register.
//   clk     : pipeline clock
//   rst_n   : asynchronous active-low reset. Loads RESET_PC.
//   advance : step the PC by PC_STEP (modulo 2^XLEN)
//   load    : take load_pc with bits [1:0] cleared. Wins over advance.
//   load_pc : redirect target
//   pc_q    : current fetch address
module pc_gen
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] pc_q
);

  // Targets are forced onto a word boundary. Low address bits from EX are ignored.
  localparam logic [XLEN-1:0] WORD_MASK = ~(PC_STEP - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_pc & WORD_MASK;
    end else if (advance) begin
      // Wraps from FFFF_FFFC to 0000_0000 with no flag.
      pc_q <= pc_q + PC_STEP;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage.
// It owns the PC, reads instruction words over the imem bus, and feeds the
// pc/instruction pair into the IF/ID register.
//   clk            : pipeline clock, rising edge
//   rst_n          : asynchronous active-low reset
//   imem           : instruction-memory bus (master side)
//   stall          : hazard unit asks fetch to hold its outputs and the PC
//   redirect_valid : EX has a taken branch or jump this cycle
//   redirect_pc    : redirect target. Bits [1:0] are ignored.
//   out_valid      : out_pc/out_inst hold a real instruction
//   out_pc         : pc of the delivered instruction (0 on bubbles)
//   out_inst       : delivered instruction (NOP_INST on bubbles)
module if_fetch
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  if_fetch_if.master      imem,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] buf_inst;
  logic            pc_advance;

  // The request depends only on state and reset, never on this cycle's inputs.
  // While in reset no request is shown, so a response that arrives then is dropped.
  assign imem.imem_req  = rst_n && (state_q == FETCH);
  assign imem.imem_addr = pc_q;

  // The PC steps exactly when an instruction moves onto out_*. That is either a
  // direct response in FETCH or the buffered word in HOLD. A redirect overrides both.
  assign pc_advance = !redirect_valid && !stall &&
                      ((state_q == HOLD) || imem.imem_ready);

  pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (pc_advance),
    .load    (redirect_valid),
    .load_pc (redirect_pc),
    .pc_q    (pc_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      buf_inst  <= NOP_INST;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= NOP_INST;
    end else begin
      case (state_q)
        FETCH: begin
          if (redirect_valid) begin
            // A same-cycle response belongs to the wrong path, so it is discarded.
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= NOP_INST;
          end else if (imem.imem_ready && !stall) begin
            out_valid <= 1'b1;
            out_pc    <= pc_q;
            out_inst  <= imem.imem_rdata;
          end else if (imem.imem_ready) begin
            // The response came in while stalled. Keep it so it is not lost,
            // and stop requesting until the stall clears.
            buf_inst <= imem.imem_rdata;
            state_q  <= HOLD;
          end else if (!stall) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= NOP_INST;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            buf_inst  <= NOP_INST;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= NOP_INST;
            state_q   <= FETCH;
          end else if (!stall) begin
            out_valid <= 1'b1;
            out_pc    <= pc_q;
            out_inst  <= buf_inst;
            state_q   <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch.
// The imem model returns 32'h1000_0000 + word index for every address, and
// always answers in the same cycle it is asked.
//   dut  : RESET_PC = 0. Its imem_ready, stall and redirect are driven by the bench.
//   dut2 : RESET_PC = FFFF_FFFC. It runs free (ready=1) to exercise the PC wrap.
module tb_if_fetch;
  import pipe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  logic        stall2;
  logic        redirect_valid2;
  logic [31:0] redirect_pc2;
  logic        out_valid2;
  logic [31:0] out_pc2;
  logic [31:0] out_inst2;

  int errors;
  int checks;

  if_fetch_if bus ();
  if_fetch_if bus2 ();

  assign bus.imem_rdata  = 32'h1000_0000 + (bus.imem_addr >> 2);
  assign bus2.imem_rdata = 32'h1000_0000 + (bus2.imem_addr >> 2);
  assign bus2.imem_ready = 1'b1;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus.master),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus2.master),
    .stall          (stall2),
    .redirect_valid (redirect_valid2),
    .redirect_pc    (redirect_pc2),
    .out_valid      (out_valid2),
    .out_pc         (out_pc2),
    .out_inst       (out_inst2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t valid=%0b pc=%h inst=%h req=%0b addr=%h | dut2 valid=%0b pc=%h inst=%h",
             $time, out_valid, out_pc, out_inst, bus.imem_req, bus.imem_addr,
             out_valid2, out_pc2, out_inst2);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    bus.imem_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.imem_ready = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_inst !== 32'h13) begin errors++; $display("FAIL reset_inst got=%h exp=00000013", out_inst); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req got=%b exp=1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got=%h exp=0", bus.imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, out_pc, exp_pc); end
      checks++; if (out_inst !== 32'h1000_0000 + 32'(i)) begin errors++; $display("FAIL stream_inst[%0d] got=%h exp=%h", i, out_inst, 32'h1000_0000 + 32'(i)); end
    end
  endtask

  task automatic test_ready_low();
    do_reset();
    tick();
    tick();
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid[%0d] got=%b exp=0", i, out_valid); end
      checks++; if (out_inst !== 32'h13) begin errors++; $display("FAIL bubble_inst[%0d] got=%h exp=00000013", i, out_inst); end
      checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL bubble_addr[%0d] got=%h exp=8", i, bus.imem_addr); end
    end
    bus.imem_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8) begin errors++; $display("FAIL wait_deliver got=%b/%h exp=1/00000008", out_valid, out_pc); end
    checks++; if (out_inst !== 32'h1000_0002) begin errors++; $display("FAIL wait_inst got=%h exp=10000002", out_inst); end
    checks++; if (bus.imem_addr !== 32'hC) begin errors++; $display("FAIL wait_next_addr got=%h exp=c", bus.imem_addr); end
    bus.imem_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wait_once got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/00000000", i, out_valid, out_pc); end
      checks++; if (out_inst !== 32'h1000_0000) begin errors++; $display("FAIL stall_inst[%0d] got=%h exp=10000000", i, out_inst); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got=%b exp=0", i, bus.imem_req); end
    end
    stall = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin errors++; $display("FAIL stall_release got=%b/%h exp=1/00000004", out_valid, out_pc); end
    checks++; if (out_inst !== 32'h1000_0001) begin errors++; $display("FAIL stall_release_inst got=%h exp=10000001", out_inst); end
    tick();
    checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL stall_no_dup got=%h exp=8", out_pc); end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got=%h exp=100", bus.imem_addr); end
    checks++; if (out_valid !== 1'b0 || out_inst !== 32'h13) begin errors++; $display("FAIL redir_bubble got=%b/%h exp=0/00000013", out_valid, out_inst); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin errors++; $display("FAIL redir_target got=%b/%h exp=1/00000100", out_valid, out_pc); end
    checks++; if (out_inst !== 32'h1000_0040) begin errors++; $display("FAIL redir_inst got=%h exp=10000040", out_inst); end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    tick();
    stall = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin errors++; $display("FAIL hold_redir_req got=%b/%h exp=1/00000200", bus.imem_req, bus.imem_addr); end
    checks++; if (out_valid !== 1'b0 || out_inst !== 32'h13) begin errors++; $display("FAIL hold_redir_bubble got=%b/%h exp=0/00000013", out_valid, out_inst); end
    stall = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_inst !== 32'h1000_0080) begin errors++; $display("FAIL hold_redir_target got=%b/%h/%h exp=1/00000200/10000080", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_wrap();
    do_reset();
    #1;
    checks++; if (bus2.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first_addr got=%h exp=fffffffc", bus2.imem_addr); end
    tick();
    checks++; if (out_valid2 !== 1'b1 || out_pc2 !== 32'hFFFF_FFFC || out_inst2 !== 32'h4FFF_FFFF) begin errors++; $display("FAIL wrap_top got=%b/%h/%h exp=1/fffffffc/4fffffff", out_valid2, out_pc2, out_inst2); end
    tick();
    checks++; if (out_pc2 !== 32'h0 || out_inst2 !== 32'h1000_0000) begin errors++; $display("FAIL wrap_zero got=%h/%h exp=00000000/10000000", out_pc2, out_inst2); end
    // Reset asserted between edges must clear the outputs immediately.
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_valid2 !== 1'b0) begin errors++; $display("FAIL async_clear got=%b/%b exp=0/0", out_valid, out_valid2); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL async_req got=%b exp=0", bus.imem_req); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.imem_addr !== 32'h0 || bus2.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL restart_addr got=%h/%h exp=00000000/fffffffc", bus.imem_addr, bus2.imem_addr); end
    tick();
    checks++; if (out_pc2 !== 32'hFFFF_FFFC || out_valid2 !== 1'b1) begin errors++; $display("FAIL restart_deliver got=%b/%h exp=1/fffffffc", out_valid2, out_pc2); end
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    bus.imem_ready  = 1'b0;
    stall2          = 1'b0;
    redirect_valid2 = 1'b0;
    redirect_pc2    = 32'h0;
    test_reset();
    test_stream();
    test_ready_low();
    test_stall();
    test_redirect();
    test_redirect_hold();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
